// File: rtl/spi_dac_pkg.sv
// rtl/spi_dac_pkg.sv - shared constants, state encoding and frame builder for the SPI DAC serializer
package spi_dac_pkg;

   localparam int FRAME_W   = 16;
   localparam int DATA_W    = 8;
   localparam int PAD_W     = 4;
   localparam int BIT_CNT_W = 5;

   localparam logic [3:0] CFG_BITS_DEF = 4'b0011;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_SETUP = 3'd1;
   localparam state_t ST_SHIFT = 3'd2;
   localparam state_t ST_CSHI  = 3'd3;
   localparam state_t ST_LDAC  = 3'd4;

   // Two's complement becomes offset binary by flipping the sign bit.
   function automatic logic [FRAME_W-1:0] build_frame(
      input logic [3:0]        cfg,
      input logic [DATA_W-1:0] d,
      input logic              signed_in
   );
      logic [DATA_W-1:0] c;
      c = signed_in ? {~d[DATA_W-1], d[DATA_W-2:0]} : d;
      return {cfg, c, {PAD_W{1'b0}}};
   endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// rtl/spi_tick_gen.sv - single-cycle tick every CLK_DIV clocks with synchronous restart
module spi_tick_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic restart_i,
   output logic tick_o
);

   localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (restart_i || tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spi_dac_serializer.sv
// rtl/spi_dac_serializer.sv - streams samples to an MCP4901-style DAC (SPI mode 0, one-deep buffer)
// Optional LDAC pulse state enabled by defining SPI_DAC_LDAC_EN.
module spi_dac_serializer
   import spi_dac_pkg::*;
#(
   parameter int         CLK_DIV   = 2,
   parameter bit         SIGNED_IN = 1'b1,
   parameter logic [3:0] CFG_BITS  = CFG_BITS_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              data_valid_strobe_i,
   output logic              cs_n_o,
   output logic              sclk_o,
   output logic              mosi_o,
   output logic              ldac_n_o,
   output logic              busy_o,
   output logic              dropped_strobe_o
);

   state_t               state_q, state_d;
   logic [FRAME_W-1:0]   shift_q, shift_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic                 cs_n_q, cs_n_d;
   logic                 sclk_q, sclk_d;
   logic                 mosi_q, mosi_d;
   logic                 busy_q, busy_d;
   logic                 drop_q, drop_d;
   logic                 buf_full_q, buf_full_d;
   logic [DATA_W-1:0]    buf_data_q, buf_data_d;
   logic [FRAME_W-1:0]   frame_load;
   logic                 tick;
   logic                 restart;

   // The buffered sample always has priority over a same-cycle strobe.
   assign frame_load = build_frame(CFG_BITS, buf_full_q ? buf_data_q : data_i, SIGNED_IN);
   assign restart    = (state_d != state_q);

   spi_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .restart_i (restart),
      .tick_o    (tick)
   );

`ifdef SPI_DAC_LDAC_EN
   logic ldac_n_q, ldac_n_d;
`endif

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      cs_n_d     = cs_n_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      busy_d     = busy_q;
      drop_d     = 1'b0;
      buf_full_d = buf_full_q;
      buf_data_d = buf_data_q;
`ifdef SPI_DAC_LDAC_EN
      ldac_n_d   = ldac_n_q;
`endif

      if (data_valid_strobe_i && busy_q) begin
         drop_d     = buf_full_q;
         buf_full_d = 1'b1;
         buf_data_d = data_i;
      end

      case (state_q)
         ST_IDLE: begin
            if (buf_full_q || data_valid_strobe_i) begin
               shift_d    = frame_load;
               mosi_d     = frame_load[FRAME_W-1];
               bit_cnt_d  = '0;
               sclk_d     = 1'b0;
               cs_n_d     = 1'b0;
               busy_d     = 1'b1;
               state_d    = ST_SETUP;
               buf_full_d = buf_full_q && data_valid_strobe_i;
               if (data_valid_strobe_i) begin
                  buf_data_d = data_i;
               end
            end
         end
         ST_SETUP: begin
            if (tick) begin
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (tick) begin
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  sclk_d    = 1'b0;
                  shift_d   = {shift_q[FRAME_W-2:0], 1'b0};
                  mosi_d    = shift_q[FRAME_W-2];
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                  if (bit_cnt_q == BIT_CNT_W'(FRAME_W - 1)) begin
                     cs_n_d  = 1'b1;
                     state_d = ST_CSHI;
                  end
               end
            end
         end
         ST_CSHI: begin
            if (tick) begin
`ifdef SPI_DAC_LDAC_EN
               ldac_n_d = 1'b0;
               state_d  = ST_LDAC;
`else
               busy_d   = 1'b0;
               state_d  = ST_IDLE;
`endif
            end
         end
`ifdef SPI_DAC_LDAC_EN
         ST_LDAC: begin
            if (tick) begin
               ldac_n_d = 1'b1;
               busy_d   = 1'b0;
               state_d  = ST_IDLE;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         cs_n_q     <= 1'b1;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         busy_q     <= 1'b0;
         drop_q     <= 1'b0;
         buf_full_q <= 1'b0;
         buf_data_q <= '0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         cs_n_q     <= cs_n_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         busy_q     <= busy_d;
         drop_q     <= drop_d;
         buf_full_q <= buf_full_d;
         buf_data_q <= buf_data_d;
      end
   end

`ifdef SPI_DAC_LDAC_EN
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ldac_n_q <= 1'b1;
      end else begin
         ldac_n_q <= ldac_n_d;
      end
   end

   assign ldac_n_o = ldac_n_q;
`else
   // Without the LDAC pin pulse the DAC latches on the rising edge of cs_n.
   assign ldac_n_o = 1'b0;
`endif

   assign cs_n_o           = cs_n_q;
   assign sclk_o           = sclk_q;
   assign mosi_o           = mosi_q;
   assign busy_o           = busy_q;
   assign dropped_strobe_o = drop_q;

endmodule

// File: tb/tb_spi_dac_serializer.sv
// tb/tb_spi_dac_serializer.sv - self-checking bench: signed and unsigned instances against a frame-timeline model
module tb_spi_dac_serializer;

   localparam int D = 2;
`ifdef SPI_DAC_LDAC_EN
   localparam bit LDAC_EN = 1'b1;
`else
   localparam bit LDAC_EN = 1'b0;
`endif
   localparam int CS_LOW   = 33 * D;
   localparam int BUSY_LEN = LDAC_EN ? 35 * D : 34 * D;

   logic       clk_i  = 1'b0;
   logic       rst_i  = 1'b0;
   logic       strobe = 1'b0;
   logic [7:0] data   = 8'h00;

   logic cs_s, sclk_s, mosi_s, ldac_s, busy_s, drop_s;
   logic cs_u, sclk_u, mosi_u, ldac_u, busy_u, drop_u;

   spi_dac_serializer #(.CLK_DIV(D), .SIGNED_IN(1'b1)) u_dut_s (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .data_i              (data),
      .data_valid_strobe_i (strobe),
      .cs_n_o              (cs_s),
      .sclk_o              (sclk_s),
      .mosi_o              (mosi_s),
      .ldac_n_o            (ldac_s),
      .busy_o              (busy_s),
      .dropped_strobe_o    (drop_s)
   );

   spi_dac_serializer #(.CLK_DIV(D), .SIGNED_IN(1'b0)) u_dut_u (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .data_i              (data),
      .data_valid_strobe_i (strobe),
      .cs_n_o              (cs_u),
      .sclk_o              (sclk_u),
      .mosi_o              (mosi_u),
      .ldac_n_o            (ldac_u),
      .busy_o              (busy_u),
      .dropped_strobe_o    (drop_u)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Offset binary is the two's complement value shifted up by half scale.
   function automatic logic [15:0] ref_frame(input logic [7:0] d, input bit s);
      logic [7:0] v;
      v = s ? d + 8'd128 : d;
      return {4'b0011, v, 4'b0000};
   endfunction

   int         now_e   = 0;
   int         start_e = 0;
   bit         active  = 1'b0;
   bit         buf_full = 1'b0;
   bit         drop_exp = 1'b0;
   logic [7:0] buf_d   = 8'h00;
   logic [7:0] cur_d   = 8'h00;
   logic [15:0] expq_s[$];
   logic [15:0] expq_u[$];
   int         drop_seen = 0;

   // {cs_n, sclk, mosi, ldac_n, busy, dropped} for the cycle after edge now_e
   function automatic logic [5:0] expect_out(input bit s);
      logic [5:0]  e;
      logic [15:0] f;
      int          o;
      int          b;
      if (!rst_i) return {1'b1, 1'b0, 1'b0, LDAC_EN, 1'b0, 1'b0};
      e = {1'b1, 1'b0, 1'b0, LDAC_EN, 1'b0, drop_exp};
      if (active && (now_e - start_e) < BUSY_LEN) begin
         o = now_e - start_e;
         f = ref_frame(cur_d, s);
         b = (o < D) ? 0 : (o - D) / (2 * D);
         if (b > 15) b = 15;
         e[5] = (o >= CS_LOW);
         e[4] = (o >= D) && (o < CS_LOW) && (((o - D) % (2 * D)) >= D);
         e[3] = (o < CS_LOW) ? f[15 - b] : 1'b0;
         e[2] = LDAC_EN ? !((o >= CS_LOW + D) && (o < CS_LOW + 2 * D)) : 1'b0;
         e[1] = 1'b1;
      end
      return e;
   endfunction

   task automatic start_frame(input logic [7:0] d);
      active  = 1'b1;
      start_e = now_e;
      cur_d   = d;
      expq_s.push_back(ref_frame(d, 1'b1));
      expq_u.push_back(ref_frame(d, 1'b0));
   endtask

   initial forever begin
      logic [5:0] es, eu;
      bit busy_now;
      @(negedge clk_i);
      es = expect_out(1'b1);
      eu = expect_out(1'b0);
      check("outs_signed",   16'({cs_s, sclk_s, mosi_s, ldac_s, busy_s, drop_s}), 16'(es));
      check("outs_unsigned", 16'({cs_u, sclk_u, mosi_u, ldac_u, busy_u, drop_u}), 16'(eu));
      if (drop_s) drop_seen++;
      busy_now = es[1];
      now_e++;
      drop_exp = 1'b0;
      if (!rst_i) begin
         active   = 1'b0;
         buf_full = 1'b0;
         expq_s.delete();
         expq_u.delete();
      end else if (!busy_now) begin
         if (buf_full) begin
            start_frame(buf_d);
            buf_full = strobe;
            buf_d    = data;
         end else if (strobe) begin
            start_frame(data);
         end
      end else if (strobe) begin
         drop_exp = buf_full;
         buf_full = 1'b1;
         buf_d    = data;
      end
   end

   logic [15:0] sh_s = 16'h0, sh_u = 16'h0, last_s = 16'h0, last_u = 16'h0;
   int nb_s = 0, nb_u = 0, ncap_s = 0, ncap_u = 0;

   initial forever begin
      @(posedge sclk_s);
      sh_s = {sh_s[14:0], mosi_s};
      nb_s++;
   end
   initial forever begin
      @(posedge sclk_u);
      sh_u = {sh_u[14:0], mosi_u};
      nb_u++;
   end
   initial forever begin
      @(negedge cs_s);
      nb_s = 0;
   end
   initial forever begin
      @(negedge cs_u);
      nb_u = 0;
   end
   initial forever begin
      @(posedge cs_s);
      if (rst_i && nb_s == 16) begin
         last_s = sh_s;
         ncap_s++;
         if (expq_s.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_signed: got unexpected frame %0h want none at %0t", sh_s, $time);
         end else begin
            check("frame_signed", sh_s, expq_s.pop_front());
         end
      end
   end
   initial forever begin
      @(posedge cs_u);
      if (rst_i && nb_u == 16) begin
         last_u = sh_u;
         ncap_u++;
         if (expq_u.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_unsigned: got unexpected frame %0h want none at %0t", sh_u, $time);
         end else begin
            check("frame_unsigned", sh_u, expq_u.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
      strobe = 1'b0;
      data   = 8'($urandom);
   endtask

   task automatic pulse(input logic [7:0] d);
      strobe = 1'b1;
      data   = d;
      step();
   endtask

   initial begin
      int cnt, first, lows, d0, c0;

      rst_i = 1'b0;
      repeat (8) begin
         strobe = 1'($urandom);
         data   = 8'($urandom);
         @(posedge clk_i);
         #1;
      end
      strobe = 1'b0;
      check("reset_outputs", 16'({cs_s, sclk_s, mosi_s, ldac_s, busy_s, drop_s}),
            16'({1'b1, 1'b0, 1'b0, LDAC_EN, 1'b0, 1'b0}));
      rst_i = 1'b1;
      repeat (20) step();
      check("no_frame_after_reset", 16'(ncap_s), 16'd0);

      pulse(8'h40);
      cnt = 0;
      while (!cs_s && cnt < 200) begin
         step();
         cnt++;
      end
      check("cs_low_cycles", 16'(cnt), 16'd66);
      first = -1;
      lows  = 0;
      for (int i = 0; i < 10; i++) begin
         if (!ldac_s) begin
            lows++;
            if (first < 0) first = i;
         end
         step();
      end
      check("ldac_offset", 16'(first), LDAC_EN ? 16'd2 : 16'd0);
      check("ldac_width",  16'(lows),  LDAC_EN ? 16'd2 : 16'd10);
      repeat (20) step();
      check("frame_40_signed",   last_s, 16'h3C00);
      check("frame_40_unsigned", last_u, 16'h3400);

      pulse(8'hFF);
      repeat (90) step();
      check("frame_ff_unsigned", last_u, 16'h3FF0);
      check("frame_ff_signed",   last_s, 16'h37F0);

      pulse(8'h80);
      repeat (90) step();
      check("frame_80_signed",   last_s, 16'h3000);
      check("frame_80_unsigned", last_u, 16'h3800);

      d0 = drop_seen;
      c0 = ncap_s;
      pulse(8'h10);
      repeat (9) step();
      pulse(8'h20);
      repeat (9) step();
      pulse(8'h30);
      repeat (200) step();
      check("drop_count",      16'(drop_seen - d0), 16'd1);
      check("drop_frames",     16'(ncap_s - c0),    16'd2);
      check("drop_last_frame", last_s,              16'h3B00);

      pulse(8'h55);
      repeat (9) step();
      pulse(8'h66);
      repeat (19) step();
      check("busy_before_reset", 16'(busy_s), 16'd1);
      c0    = ncap_s;
      rst_i = 1'b0;
      #1;
      check("async_reset_outputs", 16'({cs_s, sclk_s, mosi_s, ldac_s, busy_s, drop_s}),
            16'({1'b1, 1'b0, 1'b0, LDAC_EN, 1'b0, 1'b0}));
      repeat (3) step();
      rst_i = 1'b1;
      repeat (150) step();
      check("no_frame_after_midframe_reset", 16'(ncap_s - c0), 16'd0);

      d0 = drop_seen;
      c0 = ncap_s;
      for (int i = 0; i < 10; i++) begin
         pulse(8'($urandom));
         repeat (67) step();
      end
      repeat (100) step();
      check("periodic_drops",  16'(drop_seen - d0), 16'd0);
      check("periodic_frames", 16'(ncap_s - c0),    16'd10);

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 999) == 0) begin
            rst_i = 1'b0;
            step();
            step();
            rst_i = 1'b1;
         end else if ($urandom_range(0, 29) == 0) begin
            pulse(8'($urandom));
         end else begin
            step();
         end
      end
      repeat (100) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_dac_serializer.md
Name: spi_dac_serializer

Overview:
- Output stage directly downstream of the waveform mux.
- Consumes the selected 8-bit sample and its one-cycle valid strobe, and streams each sample to an external 8-bit SPI DAC (MCP4901-style, 16-bit write frame, SPI mode 0).
- A one-deep holding buffer absorbs samples that arrive mid-frame; loss is reported.
- The DAC is updated through an optional LDAC pulse.

Parameters:
- CLK_DIV, 2: clk_i cycles per SCLK half-period; minimum 1.
- SIGNED_IN, 1: 1 = input is two's complement and is converted to offset binary by inverting the MSB; 0 = input passed unchanged.
- CFG_BITS, 4'b0011: frame bits [15:12], i.e. write, unbuffered, gain 1x, active.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active-low
- data_i  in  8  sample from the output mux
- data_valid_strobe_i  in  1  one-cycle pulse; data_i is valid in that cycle
- cs_n_o  out  1  DAC chip select, active-low
- sclk_o  out  1  SPI clock, idle low
- mosi_o  out  1  serial data, MSB first
- ldac_n_o  out  1  DAC latch, active-low
- busy_o  out  1  frame in progress
- dropped_strobe_o  out  1  one-cycle pulse when a buffered sample is overwritten

Behaviour:
- Reset values (asynchronous): cs_n_o=1, sclk_o=0, mosi_o=0, ldac_n_o=1, busy_o=0, dropped_strobe_o=0, buffer empty, FSM=IDLE.
- Frame format: {CFG_BITS, conv(data), 4'b0000}. conv = SIGNED_IN ? {~d[7], d[6:0]} : d.
- Tick: an internal counter pulses every CLK_DIV cycles. It restarts on every FSM state entry.
- IDLE:
  - Frame source: buffer if full, else a strobe arriving this cycle.
  - With a frame source present: load the frame, cs_n_o=0, mosi_o=frame[15], busy_o=1, go to SETUP.
  - Timing: a strobe in IDLE at edge k gives cs_n_o low after edge k+1.
- SETUP: holds for 1 tick, then goes to SHIFT.
- SHIFT: 16 bits. Each bit is 1 tick with sclk low, then 1 tick with sclk high.
  - DAC samples on the rising edge.
  - mosi_o updates with the falling edge to the next bit.
  - After the 16th high phase: sclk_o=0, cs_n_o=1, go to CSHI.
- CSHI: cs_n_o high for 1 tick, then goes to LDAC (feature on) or IDLE (feature off).
- LDAC: ldac_n_o=0 for 1 tick, then goes to IDLE with busy_o=0.
- Timing at CLK_DIV=2:
  - cs_n_o low 66 cycles.
  - Frame-to-frame period 70 cycles with LDAC, 68 without.
- Buffer:
  - A strobe while busy_o=1 writes the buffer.
  - If the buffer is already full, the new sample overwrites it and dropped_strobe_o pulses the next cycle.
  - IDLE with buffer full and a simultaneous strobe: the buffer is sent and the strobe sample is written to the buffer. This is not a drop.
  - A strobe in the last LDAC/CSHI cycle is buffered and sent from IDLE next cycle.
- Reset asserted mid-frame: all outputs return to reset values immediately (async); any partial frame is abandoned and the buffer is cleared.
- data_i is sampled only on strobe cycles; a strobe with unchanged data is still sent.

Optional Feature:
- Macro: SPI_DAC_LDAC_EN.
- Defined: LDAC state present; ldac_n_o pulses low for 1 tick after CSHI.
- Undefined:
  - LDAC state removed; ldac_n_o tied 0, so the DAC updates on the rising edge of cs_n.
  - CSHI returns directly to IDLE.
  - Frame period is 34*CLK_DIV cycles.

Decomposition:
- Package spi_dac_pkg:
  - FSM state encoding: IDLE, SETUP, SHIFT, CSHI, LDAC.
  - FRAME_W=16, DATA_W=8, PAD_W=4.
  - Default CFG_BITS.
  - Bit-counter width (5).
- One sub-module, spi_tick_gen:
  - Parameterised by CLK_DIV.
  - Synchronous restart input; single-cycle tick output.
  - Uses the same async active-low reset.

Test Plan:
- Reset: hold rst_i=0 with random strobes -> cs_n_o=1, sclk_o=0, mosi_o=0, ldac_n_o=1, busy_o=0; no frame after release until a strobe.
- Single sample, SIGNED_IN=1, data_i=8'h40 -> 16 bits captured on rising sclk = 16'h3C00; cs_n_o low 66 cycles; ldac_n_o low 2 cycles, starting 2 cycles after cs_n_o rises.
- SIGNED_IN=0, data_i=8'hFF -> frame 16'h3FF0; data_i=8'h80 with SIGNED_IN=1 -> 16'h3000.
- Strobes A=8'h10 in IDLE, B=8'h20 at cycle 10, C=8'h30 at cycle 20:
  - dropped_strobe_o pulses once at cycle 21.
  - Frames sent: A then C; the second frame's cs_n_o falls 1 cycle after the first frame's LDAC ends.
- Reset asserted at cycle 30 of a frame with the buffer full -> outputs return to reset values the same cycle; no frame after release.
- Build without SPI_DAC_LDAC_EN, strobes every 68 cycles -> ldac_n_o constant 0; no drops; continuous back-to-back frames.
